// File: rtl/pipe_ctrl_stage.sv
// rtl/pipe_ctrl_stage.sv - control-bundle pipeline register with stall, squash, bubble substitution, occupancy and stall counter
// Invalid slots always carry BUBBLE, so ctrl_o is safe to consume without valid gating.
module pipe_ctrl_stage #(
    parameter int unsigned          WIDTH       = 16,
    parameter int unsigned          DEPTH       = 1,
    parameter logic [WIDTH-1:0]     BUBBLE      = '0,
    parameter int unsigned          STALL_CNT_W = 8,
    localparam int unsigned         OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    valid_i,
    input  logic [WIDTH-1:0]        ctrl_i,
    output logic                    valid_o,
    output logic [WIDTH-1:0]        ctrl_o,
    output logic [OCC_W-1:0]        occupancy_o,
    output logic [STALL_CNT_W-1:0]  stall_cnt_o
);

    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [WIDTH-1:0]       ctrl_q [DEPTH];
    logic [WIDTH-1:0]       ctrl_d [DEPTH];
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        stall_d = stall_q;
        occ_d   = '0;
        if (flush) begin
            // The same-cycle input is younger than the squash and is dropped too.
            valid_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_d[k] = BUBBLE;
            end
            stall_d = '0;
        end else if (en) begin
            valid_d[0] = valid_i;
            ctrl_d[0]  = valid_i ? ctrl_i : BUBBLE;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
            end
            stall_d = '0;
        end else if (stall_q != {STALL_CNT_W{1'b1}}) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= BUBBLE;
            end
            occ_q   <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
        end
    end

    assign valid_o     = valid_q[DEPTH-1];
    assign ctrl_o      = ctrl_q[DEPTH-1];
    assign occupancy_o = occ_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// tb/tb_pipe_ctrl_stage.sv - scoreboard bench for pipe_ctrl_stage over three parameter sets
module tb_pipe_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        valid_i = 1'b0;
    logic [15:0] ctrl_i = 16'h0000;

    always #5 clk = ~clk;

    // a: DEPTH=2, BUBBLE=0, 2-bit stall counter
    logic        a_vo;
    logic [15:0] a_co;
    logic [1:0]  a_occ;
    logic [1:0]  a_st;
    // b: DEPTH=2, BUBBLE=16'h0013
    logic        b_vo;
    logic [15:0] b_co;
    logic [1:0]  b_occ;
    logic [7:0]  b_st;
    // c: DEPTH=1, BUBBLE=0
    logic        c_vo;
    logic [15:0] c_co;
    logic [0:0]  c_occ;
    logic [7:0]  c_st;

    pipe_ctrl_stage #(.WIDTH(16), .DEPTH(2), .BUBBLE(16'h0000), .STALL_CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_i(valid_i), .ctrl_i(ctrl_i),
        .valid_o(a_vo), .ctrl_o(a_co), .occupancy_o(a_occ), .stall_cnt_o(a_st));

    pipe_ctrl_stage #(.WIDTH(16), .DEPTH(2), .BUBBLE(16'h0013), .STALL_CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_i(valid_i), .ctrl_i(ctrl_i),
        .valid_o(b_vo), .ctrl_o(b_co), .occupancy_o(b_occ), .stall_cnt_o(b_st));

    pipe_ctrl_stage #(.WIDTH(16), .DEPTH(1), .BUBBLE(16'h0000), .STALL_CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_i(valid_i), .ctrl_i(ctrl_i),
        .valid_o(c_vo), .ctrl_o(c_co), .occupancy_o(c_occ), .stall_cnt_o(c_st));

    typedef struct {
        string       name;
        int          sel;
        logic        vo;
        logic [15:0] co;
        logic [3:0]  occ;
        logic [7:0]  st;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    bit   stim_done = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end else begin
            passed++;
        end
    endtask

    // Inputs are driven on the falling edge; the expectation describes outputs after the next rising edge.
    task automatic step(input string nm, input int sel, input bit r, input bit e, input bit f,
                        input bit v, input logic [15:0] c,
                        input bit evo, input logic [15:0] eco, input int eocc, input int est);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; flush = f; valid_i = v; ctrl_i = c;
        x.name = nm; x.sel = sel; x.vo = evo; x.co = eco;
        x.occ = 4'(eocc); x.st = 8'(est);
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t        x;
        logic        vo;
        logic [15:0] co;
        logic [3:0]  occ;
        logic [7:0]  st;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                case (x.sel)
                    0: begin vo = a_vo; co = a_co; occ = 4'(a_occ); st = 8'(a_st); end
                    1: begin vo = b_vo; co = b_co; occ = 4'(b_occ); st = b_st; end
                    default: begin vo = c_vo; co = c_co; occ = 4'(c_occ); st = c_st; end
                endcase
                chk({x.name, ".valid_o"}, 16'(vo), 16'(x.vo));
                chk({x.name, ".ctrl_o"}, co, x.co);
                chk({x.name, ".occupancy_o"}, 16'(occ), 16'(x.occ));
                chk({x.name, ".stall_cnt_o"}, 16'(st), 16'(x.st));
            end
        end
    end

    initial begin : stimulus
        //        name   sel rst en fl vi ctrl_i      vo ctrl_o    occ stall
        step("a_rst1",  0, 1, 0, 0, 1, 16'hFFFF,   0, 16'h0000, 0, 0);
        step("a_rst2",  0, 1, 0, 0, 1, 16'hFFFF,   0, 16'h0000, 0, 0);
        step("a_a1",    0, 0, 1, 0, 1, 16'h00A1,   0, 16'h0000, 1, 0);
        step("a_a2",    0, 0, 1, 0, 1, 16'h00A2,   1, 16'h00A1, 2, 0);
        step("a_st1",   0, 0, 0, 0, 0, 16'h0000,   1, 16'h00A1, 2, 1);
        step("a_st2",   0, 0, 0, 0, 0, 16'h0000,   1, 16'h00A1, 2, 2);
        step("a_st3",   0, 0, 0, 0, 0, 16'h0000,   1, 16'h00A1, 2, 3);
        step("a_st4",   0, 0, 0, 0, 0, 16'h0000,   1, 16'h00A1, 2, 3);
        step("a_st5",   0, 0, 0, 0, 0, 16'h0000,   1, 16'h00A1, 2, 3);
        step("a_res",   0, 0, 1, 0, 1, 16'h00A3,   1, 16'h00A2, 2, 0);
        step("a_drn1",  0, 0, 1, 0, 0, 16'h0000,   1, 16'h00A3, 1, 0);
        step("a_drn2",  0, 0, 1, 0, 0, 16'h0000,   0, 16'h0000, 0, 0);
        step("a_s1",    0, 0, 1, 0, 1, 16'h00A1,   0, 16'h0000, 1, 0);
        step("a_s2",    0, 0, 1, 0, 1, 16'h00A2,   1, 16'h00A1, 2, 0);
        step("a_s3",    0, 0, 1, 0, 1, 16'h00A3,   1, 16'h00A2, 2, 0);
        step("a_s4",    0, 0, 1, 0, 0, 16'h0000,   1, 16'h00A3, 1, 0);
        step("a_c1",    0, 0, 1, 0, 1, 16'h00C1,   0, 16'h0000, 1, 0);
        step("a_c2",    0, 0, 1, 0, 1, 16'h00C2,   1, 16'h00C1, 2, 0);
        step("a_cst",   0, 0, 0, 0, 0, 16'h0000,   1, 16'h00C1, 2, 1);
        step("a_fl",    0, 0, 0, 1, 1, 16'h00B0,   0, 16'h0000, 0, 0);
        step("a_pf1",   0, 0, 1, 0, 0, 16'h0000,   0, 16'h0000, 0, 0);
        step("a_pf2",   0, 0, 1, 0, 0, 16'h0000,   0, 16'h0000, 0, 0);
        step("a_d1",    0, 0, 1, 0, 1, 16'h00D1,   0, 16'h0000, 1, 0);
        step("a_fle",   0, 0, 1, 1, 1, 16'h00D2,   0, 16'h0000, 0, 0);
        step("a_pfe",   0, 0, 1, 0, 0, 16'h0000,   0, 16'h0000, 0, 0);
        step("a_e1",    0, 0, 1, 0, 1, 16'h00E1,   0, 16'h0000, 1, 0);
        step("a_est",   0, 0, 0, 0, 0, 16'h0000,   0, 16'h0000, 1, 1);
        step("a_rstst", 0, 1, 0, 0, 1, 16'h00E2,   0, 16'h0000, 0, 0);

        step("b_rst",   1, 1, 0, 0, 0, 16'h0000,   0, 16'h0013, 0, 0);
        step("b_bub1",  1, 0, 1, 0, 0, 16'hDEAD,   0, 16'h0013, 0, 0);
        step("b_bub2",  1, 0, 1, 0, 0, 16'hDEAD,   0, 16'h0013, 0, 0);
        step("b_v1",    1, 0, 1, 0, 1, 16'h1234,   0, 16'h0013, 1, 0);
        step("b_v2",    1, 0, 1, 0, 0, 16'hDEAD,   1, 16'h1234, 1, 0);
        step("b_v3",    1, 0, 1, 0, 0, 16'hDEAD,   0, 16'h0013, 0, 0);
        step("b_w1",    1, 0, 1, 0, 1, 16'h5555,   0, 16'h0013, 1, 0);
        step("b_st1",   1, 0, 0, 0, 0, 16'h0000,   0, 16'h0013, 1, 1);
        step("b_st2",   1, 0, 0, 0, 0, 16'h0000,   0, 16'h0013, 1, 2);
        step("b_st3",   1, 0, 0, 0, 0, 16'h0000,   0, 16'h0013, 1, 3);
        step("b_st4",   1, 0, 0, 0, 0, 16'h0000,   0, 16'h0013, 1, 4);
        step("b_fl",    1, 0, 1, 1, 1, 16'h7777,   0, 16'h0013, 0, 0);

        step("c_rst",   2, 1, 0, 0, 0, 16'h0000,   0, 16'h0000, 0, 0);
        step("c_v1",    2, 0, 1, 0, 1, 16'h0042,   1, 16'h0042, 1, 0);
        step("c_rst2",  2, 1, 0, 0, 1, 16'h0099,   0, 16'h0000, 0, 0);
        step("c_v2",    2, 0, 1, 0, 1, 16'h0077,   1, 16'h0077, 1, 0);
        step("c_bub",   2, 0, 1, 0, 0, 16'hFFFF,   0, 16'h0000, 0, 0);
        step("c_st",    2, 0, 0, 0, 0, 16'h0000,   0, 16'h0000, 0, 1);

        @(negedge clk);
        en = 1'b0; valid_i = 1'b0;
        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        wait (stim_done);
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (2) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_ctrl_stage.md
Name: pipe_ctrl_stage

Overview:
Parametrised control-bundle pipeline register placed between datapath pipeline stages, e.g. decode to execute or execute to memory. It carries an opaque WIDTH-bit control bundle plus a valid bit through DEPTH register slices. It supports stall via en and squash via flush, and substitutes a parametrised bubble value for invalid slots. It also exports slice occupancy and a saturating stall-cycle counter for the hazard unit and performance monitoring.

Parameters:
WIDTH, 16, width of the packed control bundle (e.g. RegWrite/ResultSrc/MemWrite/Jump/Branch/ALUControl/ALUSrc/funct3); legal range 1 or more.
DEPTH, 1, number of register slices between input and output; legal range 1-8.
BUBBLE, 0 (WIDTH bits), control value driven for any invalid/squashed slot; must be a side-effect-free NOP encoding.
STALL_CNT_W, 8, width of the stall-cycle counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  advance enable; 0 = stall (hold all slices).
flush  in  1  squash every in-flight slot.
valid_i  in  1  input slot holds a real instruction.
ctrl_i  in  WIDTH  input control bundle.
valid_o  out  1  valid bit of the last slice.
ctrl_o  out  WIDTH  control bundle of the last slice.
occupancy_o  out  $clog2(DEPTH+1)  number of slices whose valid bit is 1.
stall_cnt_o  out  STALL_CNT_W  consecutive cycles held by stall, saturating.

Behaviour:
- State: DEPTH slices s[0..DEPTH-1], each a valid bit plus WIDTH control bits. s[0] is the input side; s[DEPTH-1] drives valid_o/ctrl_o directly, with no combinational path from inputs to outputs.
- Priority on each rising edge is rst > flush > en > hold.
- rst=1: all valid=0; all ctrl=BUBBLE; occupancy_o=0; stall_cnt_o=0. This applies regardless of en, and a reset while stalled still clears everything. After reset, valid_o=0 and ctrl_o=BUBBLE.
- flush=1, rst=0: all slices become valid=0 with ctrl=BUBBLE, regardless of en. The incoming valid_i/ctrl_i in that same cycle is discarded, because it is younger than the squashing event. stall_cnt_o is cleared to 0.
- en=1, no flush/rst: shift. s[0] takes valid_i and ctrl_i, with ctrl forced to BUBBLE when valid_i=0. Each s[k] takes s[k-1] for k=1..DEPTH-1. stall_cnt_o is cleared to 0.
- en=0, no flush/rst: all slices hold. stall_cnt_o increments by 1 and saturates at 2^STALL_CNT_W-1, with no wrap.
- Invariant: every slice with valid=0 holds ctrl=BUBBLE. Downstream logic may therefore consume ctrl_o without gating it by valid_o.
- Latency: with en held at 1 and no flush, an input accepted at edge N appears on ctrl_o after edge N+DEPTH-1, i.e. DEPTH cycles of register delay.
- occupancy_o is a registered count, updated in the same edge as the slices. It equals popcount(valid bits) at all times: 0 after rst or flush, and at most DEPTH.
- Simultaneous events: flush with en=0 still squashes. Flush with valid_i=1 squashes the input too. A stall never blocks reset or flush.

Test Plan:
- Reset (WIDTH=16, DEPTH=2, BUBBLE=0): hold rst for 2 cycles with en=0 and valid_i=1, ctrl_i=16'hFFFF -> valid_o=0, ctrl_o=16'h0000, occupancy_o=0, stall_cnt_o=0 after the first edge. Reset must act even though en=0.
- Streaming latency (DEPTH=2): en=1; drive valid_i=1 with ctrl_i=16'h00A1, 16'h00A2, 16'h00A3 on consecutive edges -> ctrl_o shows 16'h00A1 two edges after its launch edge, then A2, then A3. occupancy_o goes 1, 2, 2, 2.
- Stall hold plus counter saturation (STALL_CNT_W=2): with 16'h00A1 and 16'h00A2 in flight, set en=0 for 5 cycles -> ctrl_o holds 16'h00A1; stall_cnt_o reads 1, 2, 3, 3, 3. Release en=1 -> stall_cnt_o=0 and the pipeline resumes with 16'h00A2 next.
- Flush during stall: with 2 valid slices and en=0, pulse flush for 1 cycle with valid_i=1, ctrl_i=16'h00B0 -> next edge valid_o=0, ctrl_o=BUBBLE, occupancy_o=0, stall_cnt_o=0. 16'h00B0 never appears on ctrl_o.
- Bubble substitution (BUBBLE=16'h0013): en=1, valid_i=0, ctrl_i=16'hDEAD -> after DEPTH edges ctrl_o=16'h0013 and valid_o=0. Then valid_i=1 with ctrl_i=16'h1234 -> ctrl_o=16'h1234 and valid_o=1 after DEPTH edges.
- DEPTH=1 regression: en=1, valid_i=1, ctrl_i=16'h0042 -> ctrl_o=16'h0042 after exactly 1 edge. Assert rst on the next edge with en=0 -> ctrl_o=BUBBLE and valid_o=0.
